atp_section_arbiter: RTL

ATP_SECTION_ARBITER -- requirements
Module: atp_section_arbiter

---
 rtl/atp_pkg.sv | 27 ++
 rtl/atp_entry_timer.sv | 31 +++
 rtl/atp_section_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/atp_pkg.sv
// atp_pkg: shared definitions for the ATP shared-section arbiter.
// Holds the arbiter state enumeration, the highest valid section code,
// the default shared-section bounds and grant timeout, and a helper that
// tests whether a section index lies inside the shared section.
package atp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GNT_A = 3'd1,
    ST_OCC_A = 3'd2,
    ST_GNT_B = 3'd3,
    ST_OCC_B = 3'd4,
    ST_FAULT = 3'd5
  } atp_state_t;

  localparam int unsigned POS_MAX    = 11;
  localparam int unsigned SEC_LO_DEF = 4;
  localparam int unsigned SEC_HI_DEF = 7;
  localparam int unsigned TMO_DEF    = 200;

  function automatic logic in_sec(input logic [3:0] pos,
                                  input int unsigned lo,
                                  input int unsigned hi);
    return ({28'd0, pos} >= lo) && ({28'd0, pos} <= hi);
  endfunction

endpackage

// File: rtl/atp_entry_timer.sv
// atp_entry_timer: 8-bit entry counter for a granted train.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-low reset
//   i_clr - hold counter at zero
//   i_en  - count one per cycle while high
//   o_tc  - terminal count, high while the counter equals TMO-1
module atp_entry_timer #(
  parameter int unsigned TMO = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [7:0] r_cnt;

  // Stops at terminal count; the arbiter leaves the grant state on that edge.
  always_ff @(posedge clk) begin
    if (!rst || i_clr) begin
      r_cnt <= 8'd0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_tc = (r_cnt == 8'(TMO - 1));

endmodule

// File: rtl/atp_section_arbiter.sv
// atp_section_arbiter: grants two trains mutually exclusive movement
// authority into a shared single-track section [SEC_LO, SEC_HI].
// Ports:
//   clk                  - clock, rising edge
//   rst                  - synchronous active-low reset
//   req_a / req_b        - level access requests
//   pos_a / pos_b        - reported section index (0..11 valid)
//   pos_vld_a / pos_vld_b- position valid strobes
//   gnt_a / gnt_b        - movement authority (registered)
//   busy                 - section granted or occupied
//   tmo                  - one-cycle pulse when an unused grant expires
//   fault                - latched safety fault, cleared only by reset
module atp_section_arbiter
  import atp_pkg::*;
#(
  parameter int unsigned SEC_LO = SEC_LO_DEF,
  parameter int unsigned SEC_HI = SEC_HI_DEF,
  parameter int unsigned TMO    = TMO_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [3:0] pos_a,
  input  logic [3:0] pos_b,
  input  logic       pos_vld_a,
  input  logic       pos_vld_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       busy,
  output logic       tmo,
  output logic       fault
);

  atp_state_t r_state;
  atp_state_t w_nxt;
  logic       r_ptr_b;      // 1: favour B on a simultaneous request
  logic       w_ptr_nxt;
  logic       w_tmo_nxt;
  logic       r_gnt_a, r_gnt_b, r_busy, r_tmo, r_fault;
  logic       w_sec_a, w_sec_b, w_in_a, w_in_b;
  logic       w_bad, w_intr, w_tc, w_tmr_clr;

  assign w_sec_a = in_sec(pos_a, SEC_LO, SEC_HI);
  assign w_sec_b = in_sec(pos_b, SEC_LO, SEC_HI);
  assign w_in_a  = pos_vld_a && w_sec_a;
  assign w_in_b  = pos_vld_b && w_sec_b;
  assign w_bad   = (pos_vld_a && (pos_a > 4'(POS_MAX))) ||
                   (pos_vld_b && (pos_b > 4'(POS_MAX)));

  // Counter runs only while waiting for entry; it is held at zero in every
  // other state so it starts from zero on each new grant.
  assign w_tmr_clr = !((r_state == ST_GNT_A) || (r_state == ST_GNT_B));

  atp_entry_timer #(.TMO(TMO)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .i_clr(w_tmr_clr),
    .i_en (!w_tmr_clr),
    .o_tc (w_tc)
  );

  // A train without authority reporting itself inside the section.
  always_comb begin
    w_intr = 1'b0;
    case (r_state)
      ST_IDLE:            w_intr = w_in_a || w_in_b;
      ST_GNT_A, ST_OCC_A: w_intr = w_in_b;
      ST_GNT_B, ST_OCC_B: w_intr = w_in_a;
      default:            w_intr = 1'b0;
    endcase
  end

  // Next state; in GNT_x entry beats cancel, cancel beats timeout.
  always_comb begin
    w_nxt     = r_state;
    w_ptr_nxt = r_ptr_b;
    w_tmo_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_a && req_b)  w_nxt = r_ptr_b ? ST_GNT_B : ST_GNT_A;
        else if (req_a)      w_nxt = ST_GNT_A;
        else if (req_b)      w_nxt = ST_GNT_B;
      end
      ST_GNT_A: begin
        if (w_in_a)          w_nxt = ST_OCC_A;
        else if (!req_a)     w_nxt = ST_IDLE;
        else if (w_tc) begin
          w_nxt     = ST_IDLE;
          w_tmo_nxt = 1'b1;
          w_ptr_nxt = 1'b1;
        end
      end
      ST_OCC_A: begin
        if (pos_vld_a && !w_sec_a) begin
          w_nxt     = ST_IDLE;
          w_ptr_nxt = 1'b1;
        end
      end
      ST_GNT_B: begin
        if (w_in_b)          w_nxt = ST_OCC_B;
        else if (!req_b)     w_nxt = ST_IDLE;
        else if (w_tc) begin
          w_nxt     = ST_IDLE;
          w_tmo_nxt = 1'b1;
          w_ptr_nxt = 1'b0;
        end
      end
      ST_OCC_B: begin
        if (pos_vld_b && !w_sec_b) begin
          w_nxt     = ST_IDLE;
          w_ptr_nxt = 1'b0;
        end
      end
      ST_FAULT: w_nxt = ST_FAULT;
      default:  w_nxt = ST_FAULT;
    endcase
    // Safety hazards override any entry, exit or timeout in the same cycle.
    if ((r_state != ST_FAULT) && (w_bad || w_intr)) begin
      w_nxt     = ST_FAULT;
      w_tmo_nxt = 1'b0;
      w_ptr_nxt = r_ptr_b;
    end
  end

  // Outputs are registered from the next state so they match the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_ptr_b <= 1'b0;
      r_gnt_a <= 1'b0;
      r_gnt_b <= 1'b0;
      r_busy  <= 1'b0;
      r_tmo   <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_ptr_b <= w_ptr_nxt;
      r_gnt_a <= (w_nxt == ST_GNT_A) || (w_nxt == ST_OCC_A);
      r_gnt_b <= (w_nxt == ST_GNT_B) || (w_nxt == ST_OCC_B);
      r_busy  <= (w_nxt != ST_IDLE) && (w_nxt != ST_FAULT);
      r_tmo   <= w_tmo_nxt;
      r_fault <= (w_nxt == ST_FAULT);
    end
  end

  assign gnt_a = r_gnt_a;
  assign gnt_b = r_gnt_b;
  assign busy  = r_busy;
  assign tmo   = r_tmo;
  assign fault = r_fault;

endmodule
